// File: rtl/alu_seq_if.sv
// Operand/result bundle for alu_seq: operands and opcode with in_valid/in_ready,
// results and status flags with out_valid/out_ready.
interface alu_seq_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [2:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_ovf;
  logic             flag_dz;

  modport master (
    output rs, rt, op, in_valid, out_ready,
    input  in_ready, out_valid, result, result_hi,
    input  flag_zero, flag_carry, flag_ovf, flag_dz
  );

  modport slave (
    input  rs, rt, op, in_valid, out_ready,
    output in_ready, out_valid, result, result_hi,
    output flag_zero, flag_carry, flag_ovf, flag_dz
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: add/sub/logic/sltu in 1 cycle, unsigned MUL/DIV in WIDTH+1 cycles.
// Result held in DONE until out_ready; a new op is accepted only from IDLE.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_DIV  = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] hi_q, hi_nx, lo_q, lo_nx, b_q, b_nx;
  logic [2:0]       op_q, op_nx;
  logic [CW-1:0]    cnt_q, cnt_nx;
  logic [WIDTH-1:0] res_q, res_nx, res_hi_q, res_hi_nx;
  logic             zero_q, zero_nx, carry_q, carry_nx, ovf_q, ovf_nx, dz_q, dz_nx;
  logic             load_res;

  logic [WIDTH:0]   sum, diff, mul_acc, rem_sh;
  logic [WIDTH-1:0] rem_sub, step_hi, step_lo;

  assign sum     = {1'b0, bus.rs} + {1'b0, bus.rt};
  assign diff    = {1'b0, bus.rs} - {1'b0, bus.rt};
  assign mul_acc = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign rem_sh  = {hi_q, lo_q[WIDTH-1]};
  assign rem_sub = rem_sh[WIDTH-1:0] - b_q;

  // hi_q:lo_q is the product shifting right (MUL) or remainder:dividend shifting left (DIV)
  always_comb begin
    step_hi = mul_acc[WIDTH:1];
    step_lo = {mul_acc[0], lo_q[WIDTH-1:1]};
    if (op_q == OP_DIV) begin
      if (rem_sh >= {1'b0, b_q}) begin
        step_hi = rem_sub;
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_nx  = state;
    hi_nx     = hi_q;
    lo_nx     = lo_q;
    b_nx      = b_q;
    op_nx     = op_q;
    cnt_nx    = cnt_q;
    res_nx    = res_q;
    res_hi_nx = res_hi_q;
    zero_nx   = zero_q;
    carry_nx  = carry_q;
    ovf_nx    = ovf_q;
    dz_nx     = dz_q;
    load_res  = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          op_nx = bus.op;
          b_nx  = bus.rt;
          if (bus.op == OP_MUL || (bus.op == OP_DIV && bus.rt != '0)) begin
            hi_nx    = '0;
            lo_nx    = bus.rs;
            cnt_nx   = CW'(WIDTH);
            state_nx = EXEC;
          end else begin
            load_res  = 1'b1;
            res_hi_nx = '0;
            carry_nx  = 1'b0;
            ovf_nx    = 1'b0;
            dz_nx     = 1'b0;
            state_nx  = DONE;
            case (bus.op)
              OP_ADD: begin
                res_nx   = sum[WIDTH-1:0];
                carry_nx = sum[WIDTH];
                ovf_nx   = (bus.rs[WIDTH-1] == bus.rt[WIDTH-1]) &&
                           (sum[WIDTH-1] != bus.rs[WIDTH-1]);
              end
              OP_SUB: begin
                res_nx   = diff[WIDTH-1:0];
                carry_nx = diff[WIDTH];
                ovf_nx   = (bus.rs[WIDTH-1] != bus.rt[WIDTH-1]) &&
                           (diff[WIDTH-1] != bus.rs[WIDTH-1]);
              end
              OP_AND:  res_nx = bus.rs & bus.rt;
              OP_OR:   res_nx = bus.rs | bus.rt;
              OP_XOR:  res_nx = bus.rs ^ bus.rt;
              OP_SLTU: res_nx = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
              default: begin
                res_nx    = '1;
                res_hi_nx = bus.rs;
                dz_nx     = 1'b1;
              end
            endcase
          end
        end
      end
      EXEC: begin
        hi_nx  = step_hi;
        lo_nx  = step_lo;
        cnt_nx = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          load_res  = 1'b1;
          res_nx    = step_lo;
          res_hi_nx = step_hi;
          carry_nx  = 1'b0;
          ovf_nx    = 1'b0;
          dz_nx     = 1'b0;
          state_nx  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (load_res) zero_nx = (res_nx == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state    <= state_nx;
      hi_q     <= hi_nx;
      lo_q     <= lo_nx;
      b_q      <= b_nx;
      op_q     <= op_nx;
      cnt_q    <= cnt_nx;
      res_q    <= res_nx;
      res_hi_q <= res_hi_nx;
      zero_q   <= zero_nx;
      carry_q  <= carry_nx;
      ovf_q    <= ovf_nx;
      dz_q     <= dz_nx;
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.result     = res_q;
  assign bus.result_hi  = res_hi_q;
  assign bus.flag_zero  = zero_q;
  assign bus.flag_carry = carry_q;
  assign bus.flag_ovf   = ovf_q;
  assign bus.flag_dz    = dz_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: WIDTH=4 instance checked every cycle against an arithmetic model,
// plus hand-computed literals; WIDTH=8 instance checked with directed MUL/DIV.
module tb_alu_seq;
  localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3;
  localparam int OP_XOR = 4, OP_SLTU = 5, OP_MUL = 6, OP_DIV = 7;

  typedef struct {
    int res;
    int hi;
    bit z, c, o, dz;
    int lat;
  } want_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  want_t want_q[$];

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(4)) bus4();
  alu_seq_if #(.WIDTH(8)) bus8();

  alu_seq #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  alu_seq #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Results straight from the arithmetic definitions of each opcode.
  function automatic want_t model(input int w, input int op, input int a, input int b);
    want_t e;
    int mask, half, sa, sb, s;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    e = '{default: 0};
    e.lat = 1;
    case (op)
      OP_ADD: begin
        s = a + b; e.res = s & mask; e.c = (s > mask);
        s = sa + sb; e.o = (s >= half) || (s < -half);
      end
      OP_SUB: begin
        e.res = (a - b) & mask; e.c = (a < b);
        s = sa - sb; e.o = (s >= half) || (s < -half);
      end
      OP_AND:  e.res = a & b;
      OP_OR:   e.res = a | b;
      OP_XOR:  e.res = a ^ b;
      OP_SLTU: e.res = (a < b) ? 1 : 0;
      OP_MUL: begin
        s = a * b; e.res = s & mask; e.hi = (s >> w) & mask; e.lat = w + 1;
      end
      default: begin
        if (b == 0) begin
          e.res = mask; e.hi = a; e.dz = 1'b1;
        end else begin
          e.res = a / b; e.hi = a % b; e.lat = w + 1;
        end
      end
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Per-cycle compare for the WIDTH=4 instance; inputs change at posedge+1, sampled here.
  always @(negedge clk) begin
    bit pending;
    cyc++;
    if (!rst_n) begin
      want_q.delete();
    end else begin
      pending = (want_q.size() > 0);
      chk("in_ready", int'(bus4.in_ready), pending ? 0 : 1);
      chk("out_valid", int'(bus4.out_valid),
          (pending && (cyc - acc_cyc >= want_q[0].lat)) ? 1 : 0);
      if (pending && bus4.out_valid) begin
        chk("result", int'(bus4.result), want_q[0].res);
        chk("result_hi", int'(bus4.result_hi), want_q[0].hi);
        chk("flag_zero", int'(bus4.flag_zero), int'(want_q[0].z));
        chk("flag_carry", int'(bus4.flag_carry), int'(want_q[0].c));
        chk("flag_ovf", int'(bus4.flag_ovf), int'(want_q[0].o));
        chk("flag_dz", int'(bus4.flag_dz), int'(want_q[0].dz));
        if (bus4.out_ready) void'(want_q.pop_front());
      end
      if (bus4.in_valid && bus4.in_ready) begin
        want_q.push_back(model(4, int'(bus4.op), int'(bus4.rs), int'(bus4.rt)));
        acc_cyc = cyc;
      end
    end
  end

  // Issue one op on the 4-bit DUT; hold>0 leaves it in DONE with out_ready low.
  task automatic do_op4(input int a, input int b, input int op, input int hold,
                        output int r, output int h, output logic [3:0] f, output int lat);
    int n;
    @(posedge clk); #1;
    bus4.rs = 4'(a); bus4.rt = 4'(b); bus4.op = 3'(op);
    bus4.in_valid = 1'b1;
    bus4.out_ready = (hold == 0);
    @(negedge clk);
    for (n = 0; n < 50 && !bus4.in_ready; n++) @(negedge clk);
    if (!bus4.in_ready) chk("accept_timeout4", 0, 1);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus4.out_valid && lat < 40);
    if (!bus4.out_valid) chk("valid_timeout4", 0, 1);
    r = int'(bus4.result);
    h = int'(bus4.result_hi);
    f = {bus4.flag_dz, bus4.flag_ovf, bus4.flag_carry, bus4.flag_zero};
    if (hold == 0) begin
      @(posedge clk); #1;
      bus4.out_ready = 1'b0;
    end
  endtask

  task automatic do_op8(input int a, input int b, input int op,
                        output int r, output int h, output int lat);
    int n;
    @(posedge clk); #1;
    bus8.rs = 8'(a); bus8.rt = 8'(b); bus8.op = 3'(op);
    bus8.in_valid = 1'b1;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    for (n = 0; n < 50 && !bus8.in_ready; n++) @(negedge clk);
    if (!bus8.in_ready) chk("accept_timeout8", 0, 1);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus8.out_valid && lat < 40);
    if (!bus8.out_valid) chk("valid_timeout8", 0, 1);
    r = int'(bus8.result);
    h = int'(bus8.result_hi);
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, h, lat;
    logic [3:0] f;
    want_t m;
    int ta[10] = '{5, 12, 3, 9, 7, 8, 15, 0, 0, 15};
    int tb[10] = '{10, 10, 9, 3, 1, 1, 15, 7, 5, 1};
    int to[10] = '{OP_OR, OP_XOR, OP_SLTU, OP_SLTU, OP_ADD, OP_SUB, OP_MUL, OP_MUL, OP_DIV, OP_DIV};

    bus4.rs = '0; bus4.rt = '0; bus4.op = '0; bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    bus8.rs = '0; bus8.rt = '0; bus8.op = '0; bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", int'(bus4.in_ready), 1);
    chk("rst_out_valid", int'(bus4.out_valid), 0);
    chk("rst_result", int'(bus4.result), 0);
    chk("rst_result_hi", int'(bus4.result_hi), 0);
    chk("rst_flags", int'({bus4.flag_dz, bus4.flag_ovf, bus4.flag_carry, bus4.flag_zero}), 0);
    chk("rst8_result", int'(bus8.result), 0);

    // flags packed as {dz, ovf, carry, zero}
    do_op4(9, 8, OP_ADD, 0, r, h, f, lat);
    chk("add_res", r, 1); chk("add_hi", h, 0); chk("add_flags", int'(f), 6); chk("add_lat", lat, 1);

    do_op4(3, 3, OP_SUB, 0, r, h, f, lat);
    chk("sub_eq_res", r, 0); chk("sub_eq_flags", int'(f), 1);

    do_op4(2, 5, OP_SUB, 0, r, h, f, lat);
    chk("sub_lt_res", r, 13); chk("sub_lt_flags", int'(f), 2);

    do_op4(13, 11, OP_MUL, 0, r, h, f, lat);
    chk("mul_res", r, 15); chk("mul_hi", h, 8); chk("mul_lat", lat, 5);

    do_op4(13, 3, OP_DIV, 0, r, h, f, lat);
    chk("div_q", r, 4); chk("div_r", h, 1); chk("div_lat", lat, 5);

    do_op4(13, 0, OP_DIV, 0, r, h, f, lat);
    chk("dz_res", r, 15); chk("dz_hi", h, 13); chk("dz_flags", int'(f), 8); chk("dz_lat", lat, 1);

    // Backpressure with operands changing underneath the held result.
    do_op4(12, 10, OP_AND, 3, r, h, f, lat);
    chk("and_res", r, 8);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus4.rs = ~bus4.rs; bus4.rt = bus4.rt + 4'd3; bus4.op = bus4.op + 3'd1;
    end
    @(negedge clk);
    chk("bp_result", int'(bus4.result), 8);
    chk("bp_out_valid", int'(bus4.out_valid), 1);
    chk("bp_in_ready", int'(bus4.in_ready), 0);
    @(posedge clk); #1 bus4.out_ready = 1'b1;
    @(posedge clk); #1 bus4.out_ready = 1'b0;
    chk("bp_drain_in_ready", int'(bus4.in_ready), 1);

    for (int i = 0; i < 10; i++) do_op4(ta[i], tb[i], to[i], 0, r, h, f, lat);

    // Pin the model on a few known answers.
    m = model(4, OP_ADD, 7, 1);
    chk("model_add_ovf", int'(m.o), 1);
    m = model(8, OP_MUL, 200, 255);
    chk("model_mul8", m.hi * 256 + m.res, 51000);

    // Asynchronous reset two cycles into a multiply.
    @(posedge clk); #1;
    bus4.rs = 4'd13; bus4.rt = 4'd11; bus4.op = 3'(OP_MUL);
    bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    @(posedge clk); #1 bus4.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(bus4.out_valid), 0);
    chk("arst_in_ready", int'(bus4.in_ready), 1);
    chk("arst_result", int'(bus4.result), 0);
    chk("arst_result_hi", int'(bus4.result_hi), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    bus4.out_ready = 1'b0;
    do_op4(1, 1, OP_ADD, 0, r, h, f, lat);
    chk("post_rst_add", r, 2); chk("post_rst_lat", lat, 1);

    do_op8(200, 255, OP_MUL, r, h, lat);
    chk("mul8_prod", h * 256 + r, 51000);
    chk("mul8_lat", lat, 9);
    m = model(8, OP_DIV, 200, 7);
    do_op8(200, 7, OP_DIV, r, h, lat);
    chk("div8_q", r, 28); chk("div8_r", h, 4);
    chk("div8_model_q", r, m.res); chk("div8_lat", lat, 9);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised sequential ALU; next generation of the 4-bit combinational ALU behind the Tiny Tapeout top.
- Adds WIDTH generalisation, an 8-operation set including iterative multiply and divide, status flags, and valid/ready handshakes on both sides.
- Sits between the top-level pin mapping (operands on ui_in, opcode and handshakes on uio) and uo_out.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..16.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- rs  input  WIDTH  operand A
- rt  input  WIDTH  operand B
- op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLTU, 110 MUL, 111 DIV
- in_valid  input  1  operands and opcode valid
- in_ready  output  1  block can accept an operation
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  main result (MUL low half, DIV quotient)
- result_hi  output  WIDTH  MUL high half, DIV remainder, 0 for all other ops
- flag_zero  output  1  result == 0 (result_hi ignored)
- flag_carry  output  1  ADD carry-out; SUB borrow (rs < rt unsigned); 0 otherwise
- flag_ovf  output  1  signed two's-complement overflow for ADD/SUB; 0 otherwise
- flag_dz  output  1  DIV with rt == 0

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE, in_ready=1, out_valid=0; result, result_hi and all flags = 0. Operand and iteration registers are cleared.
- FSM states: IDLE, EXEC, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE, on in_valid: capture rs, rt and op.
  - ADD, SUB, AND, OR, XOR, SLTU: compute and go to DONE. Latency 1: out_valid rises on the first edge after the accept edge.
  - MUL, DIV with rt != 0: load the iteration counter with WIDTH and go to EXEC.
  - DIV with rt == 0: go to DONE directly with result = all ones, result_hi = rs, flag_dz = 1. Latency 1.
- EXEC: one shift-add (MUL) or one restoring-divide step (DIV) per cycle, unsigned. Counter decrements; when it reaches 0, go to DONE. Latency WIDTH+1 edges from accept to out_valid.
- DONE: hold result, result_hi and flags stable until out_ready=1. On the edge with out_ready=1, go to IDLE.
  - An operation is accepted no earlier than the edge after the drain, so throughput is at most one op per 2 cycles for single-cycle ops.
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH.
  - SLTU result = 1 if rs < rt unsigned, else 0.
  - MUL full product = {result_hi, result}.
  - DIV: rs = result*rt + result_hi, with result_hi < rt.
- Inputs are sampled only on the accept edge; changes to rs, rt or op during EXEC or DONE have no effect.
- in_valid asserted outside IDLE is ignored; the producer must hold it until in_ready.
- Reset asserted in any state, including mid-EXEC, aborts the operation immediately and restores the reset values. There is no partial output.

Test Plan:
- WIDTH=4, ADD rs=9 rt=8, out_ready=1 -> out_valid one cycle after accept; result=1, result_hi=0, carry=1, ovf=1, zero=0.
- SUB rs=3 rt=3 then SUB rs=2 rt=5 -> first: result=0, zero=1, carry=0. Second: result=13, carry=1, ovf=0.
- MUL rs=13 rt=11 -> in_ready low for 5 cycles; out_valid 5 edges after accept; result=0xF, result_hi=0x8. Repeat with WIDTH=8, 200*255 -> {hi,lo}=0xC738, out_valid 9 edges after accept.
- DIV rs=13 rt=3 -> result=4, result_hi=1, latency 5. DIV rs=13 rt=0 -> result=0xF, result_hi=0xD, dz=1, latency 1.
- Backpressure: AND rs=0xC rt=0xA, out_ready held 0 for 3 cycles, rs/rt toggled meanwhile -> result stays 0x8, out_valid stays 1, in_ready stays 0. Raise out_ready -> IDLE next edge, in_ready=1.
- Reset mid-operation: start MUL, assert rst_n=0 two cycles in (asynchronously, between edges) -> out_valid=0, in_ready=1 and outputs 0 immediately. After release, a new ADD 1+1 returns 2.
